ram_dp: RTL and testbench

//  Simple dual-port memory: one synchronous write port, one asynchronous read port, one clock.

---
 rtl/ram_dp.sv | 66 ++++++
 tb/tb_ram_dp.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_dp.sv
// ---------------------------------------------------------------------------
// ram_dp: simple dual-port memory, one clock.
//   Synchronous write port and asynchronous (combinational) read port over
//   2**addr_width words of data_width bits. Serves as the processor's
//   data/instruction store: the store path drives the write port, and the
//   load/fetch logic consumes the read port combinationally.
//
// Ports
//   CLK       in   clock; writes take effect on its rising edge
//   RESET     in   asynchronous active-high reset; clears every word at once
//   ADRR_W    in   write address
//   ENABLE_W  in   write enable, sampled at rising CLK
//   Q_W       in   write data
//   ADRR_R    in   read address
//   Q_R       out  read data, mem[ADRR_R] with zero latency
// ---------------------------------------------------------------------------
module ram_dp #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [addr_width-1:0] ADRR_W,
    input  logic                  ENABLE_W,
    input  logic [data_width-1:0] Q_W,
    input  logic [addr_width-1:0] ADRR_R,
    output logic [data_width-1:0] Q_R
);

    localparam int DEPTH = 2 ** addr_width;

    logic [data_width-1:0] mem_q [DEPTH];
    logic                  wr_en_d;

    // Compare against a known 1 so an X/Z enable in 4-state simulation
    // evaluates as "no write" rather than corrupting the addressed word.
    always_comb begin
        wr_en_d = 1'b0;
        if (ENABLE_W == 1'b1) begin
            wr_en_d = 1'b1;
        end
    end

    // Reset clears the whole array without a clock and wins over any write
    // presented in the same cycle. Release of RESET is expected to be
    // synchronised to CLK by the reset source.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[ADRR_W] <= Q_W;
        end
    end

    // Purely combinational read: no bypass of Q_W, so a read of the word
    // being written shows the old value until the rising edge commits it.
    always_comb begin
        Q_R = mem_q[ADRR_R];
        if (RESET) begin
            Q_R = '0;
        end
    end

endmodule

// File: tb/tb_ram_dp.sv
module tb_ram_dp;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] adrr_w;
    logic          enable_w;
    logic [DW-1:0] q_w;
    logic [AW-1:0] adrr_r;
    logic [DW-1:0] q_r;

    int errors = 0;
    int checks = 0;

    ram_dp #(.addr_width(AW), .data_width(DW)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .ADRR_W   (adrr_w),
        .ENABLE_W (enable_w),
        .Q_W      (q_w),
        .ADRR_R   (adrr_r),
        .Q_R      (q_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_before;  // Q_R just before the rising edge
        logic [DW-1:0] exp_after;   // Q_R just after the rising edge
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        //             en    wa     wd            ra     before        after
        vecs[0]  = '{1'b1, 10'd0,    32'h12153524, 10'd0,    32'h00000000, 32'h12153524};
        vecs[1]  = '{1'b1, 10'd1,    32'hC0895E81, 10'd1,    32'h00000000, 32'hC0895E81};
        vecs[2]  = '{1'b1, 10'd2,    32'h8484D609, 10'd2,    32'h00000000, 32'h8484D609};
        // read-during-write on word 2: old value until the edge, never Q_W early
        vecs[3]  = '{1'b1, 10'd2,    32'hB1F05663, 10'd2,    32'h8484D609, 32'hB1F05663};
        vecs[4]  = '{1'b0, 10'd2,    32'h00000000, 10'd2,    32'hB1F05663, 32'hB1F05663};
        vecs[5]  = '{1'b1, 10'd2,    32'h06B97B0D, 10'd2,    32'hB1F05663, 32'h06B97B0D};
        vecs[6]  = '{1'b0, 10'd2,    32'h00000000, 10'd2,    32'h06B97B0D, 32'h06B97B0D};
        // enable low: three edges presenting all-ones to word 2
        vecs[7]  = '{1'b0, 10'd2,    32'hFFFFFFFF, 10'd2,    32'h06B97B0D, 32'h06B97B0D};
        vecs[8]  = '{1'b0, 10'd2,    32'hFFFFFFFF, 10'd2,    32'h06B97B0D, 32'h06B97B0D};
        vecs[9]  = '{1'b0, 10'd2,    32'hFFFFFFFF, 10'd2,    32'h06B97B0D, 32'h06B97B0D};
        // top address, then write-after-write to it
        vecs[10] = '{1'b1, 10'd1023, 32'hA5A5A5A5, 10'd1023, 32'h00000000, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 10'd1023, 32'h5A5A5A5A, 10'd1023, 32'hA5A5A5A5, 32'h5A5A5A5A};
        // word 0 untouched by the later traffic
        vecs[12] = '{1'b0, 10'd0,    32'h00000000, 10'd0,    32'h12153524, 32'h12153524};

        rst = 1'b1; adrr_w = '0; enable_w = 1'b0; q_w = '0; adrr_r = '0;

        // reset held two cycles, released on the falling edge
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        adrr_r = 10'd0;    #1 chk("reset_rd0",    q_r, 32'h0);
        adrr_r = 10'd1;    #1 chk("reset_rd1",    q_r, 32'h0);
        adrr_r = 10'd2;    #1 chk("reset_rd2",    q_r, 32'h0);
        adrr_r = 10'd1023; #1 chk("reset_rd1023", q_r, 32'h0);

        // table: drive on falling edge, check before and after the rising edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            enable_w = vecs[i].en;
            adrr_w   = vecs[i].wa;
            q_w      = vecs[i].wd;
            adrr_r   = vecs[i].ra;
            #1 chk($sformatf("vec%0d_before", i), q_r, vecs[i].exp_before);
            @(posedge clk);
            #1 chk($sformatf("vec%0d_after", i), q_r, vecs[i].exp_after);
        end

        // read address changed mid-cycle, no clock in between
        @(negedge clk);
        enable_w = 1'b0;
        #1;
        adrr_r = 10'd1;    #1 chk("mid_rd1",    q_r, 32'hC0895E81);
        adrr_r = 10'd2;    #1 chk("mid_rd2",    q_r, 32'h06B97B0D);
        adrr_r = 10'd1023; #1 chk("mid_rd1023", q_r, 32'h5A5A5A5A);
        adrr_r = 10'd0;    #1 chk("mid_rd0",    q_r, 32'h12153524);

        // async reset between edges; a write attempted during reset is lost
        adrr_r = 10'd2;
        #1 rst = 1'b1;
        #1 chk("async_rst_rd2", q_r, 32'h0);
        enable_w = 1'b1; adrr_w = 10'd2; q_w = 32'hDEADBEEF;
        @(posedge clk);
        #1 chk("rst_write_ignored", q_r, 32'h0);
        @(negedge clk);
        enable_w = 1'b0;
        rst = 1'b0;
        #1 chk("post_rst_rd2", q_r, 32'h0);
        adrr_r = 10'd0;    #1 chk("post_rst_rd0",    q_r, 32'h0);
        adrr_r = 10'd1023; #1 chk("post_rst_rd1023", q_r, 32'h0);

        // memory usable again after reset
        @(negedge clk);
        enable_w = 1'b1; adrr_w = 10'd5; q_w = 32'h0BADF00D; adrr_r = 10'd5;
        @(posedge clk);
        #1 chk("post_rst_write", q_r, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
